// File: rtl/hs_npu_systolic_ctrl_if.sv
// Signal bundle between the systolic sequencer and its neighbours: the tile scheduler
// command, the operand buffer read port, the MAC array port and the aligned result stream.
interface hs_npu_systolic_ctrl_if #(
    parameter int SIZE  = 8,
    parameter int ROW_W = 16
);
    logic                  start_in;
    logic [ROW_W-1:0]      rows_in;
    logic [ROW_W-1:0]      base_in;
    logic [SIZE-1:0][31:0] bias_in;

    logic                  rd_en_out;
    logic [ROW_W-1:0]      rd_addr_out;
    logic [SIZE-1:0][15:0] rd_a_in;
    logic [SIZE-1:0][15:0] rd_b_in;

    logic                  arr_en_out;
    logic [SIZE-1:0][15:0] arr_a_out;
    logic [SIZE-1:0][15:0] arr_b_out;
    logic [SIZE-1:0][31:0] arr_sum_out;
    logic [SIZE-1:0][31:0] arr_res_in;

    logic                  res_valid_out;
    logic [SIZE-1:0][31:0] res_out;
    logic                  busy_out;
    logic                  done_out;

    modport slave (
        input  start_in, rows_in, base_in, bias_in, rd_a_in, rd_b_in, arr_res_in,
        output rd_en_out, rd_addr_out, arr_en_out, arr_a_out, arr_b_out, arr_sum_out,
               res_valid_out, res_out, busy_out, done_out
    );

    modport master (
        output start_in, rows_in, base_in, bias_in, rd_a_in, rd_b_in, arr_res_in,
        input  rd_en_out, rd_addr_out, arr_en_out, arr_a_out, arr_b_out, arr_sum_out,
               res_valid_out, res_out, busy_out, done_out
    );
endinterface

// File: rtl/hs_npu_systolic_ctrl.sv
// Sequencer for a SIZE x SIZE systolic MAC array: streams operand rows with a per-lane
// input skew, holds the array enabled while data is in flight, and de-skews the results.
module hs_npu_systolic_ctrl #(
    parameter int SIZE  = 8,
    parameter int ROW_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hs_npu_systolic_ctrl_if.slave bus
);
    localparam int RES_LAT = 3 * SIZE - 1;

    typedef logic [15:0] short_t;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      rows_q, rows_d;
    logic [ROW_W-1:0]      addr_q, addr_d;
    logic [ROW_W-1:0]      issued_q, issued_d;
    logic [ROW_W-1:0]      emitted_q, emitted_d;
    word_t [SIZE-1:0]      bias_q, bias_d;
    logic                  rd_vld_q;
    logic [RES_LAT-1:0]    res_vld_q;

    logic [ROW_W-1:0]      last_row;
    logic                  rd_en;
    logic                  res_vld;
    short_t [SIZE-1:0]     a_gated, b_gated;
    word_t  [SIZE-1:0]     aligned;

    assign last_row = rows_q - ROW_W'(1);
    assign rd_en    = (state_q == S_FEED);
    assign res_vld  = res_vld_q[RES_LAT-1];

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rows_q    <= '0;
            addr_q    <= '0;
            issued_q  <= '0;
            emitted_q <= '0;
            bias_q    <= '0;
            rd_vld_q  <= 1'b0;
            res_vld_q <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            addr_q    <= addr_d;
            issued_q  <= issued_d;
            emitted_q <= emitted_d;
            bias_q    <= bias_d;
            rd_vld_q  <= rd_en;
            res_vld_q <= {res_vld_q[RES_LAT-2:0], rd_en};
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no branch
        // of the case below can leave a signal unassigned and infer a latch.
        state_d   = state_q;
        rows_d    = rows_q;
        addr_d    = addr_q;
        issued_d  = issued_q;
        emitted_d = emitted_q;
        bias_d    = bias_q;

        if (res_vld) emitted_d = emitted_q + ROW_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_in) begin
                    rows_d    = bus.rows_in;
                    addr_d    = bus.base_in;
                    bias_d    = bus.bias_in;
                    issued_d  = '0;
                    emitted_d = '0;
                    state_d   = (bus.rows_in == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                addr_d   = addr_q + ROW_W'(1);
                issued_d = issued_q + ROW_W'(1);
                if (issued_q == last_row) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (res_vld && (emitted_q == last_row)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Buffer data is only meaningful the cycle after a read; otherwise lanes carry zeros.
    assign a_gated = rd_vld_q ? bus.rd_a_in : '0;
    assign b_gated = rd_vld_q ? bus.rd_b_in : '0;

    assign bus.arr_a_out[0] = a_gated[0];
    assign bus.arr_b_out[0] = b_gated[0];

    for (genvar k = 1; k < SIZE; k++) begin : g_skew
        short_t [k-1:0] a_sr_q, b_sr_q;

        // NOTE: the skew/de-skew lines are reset so an aborted job leaves no stale
        // operands or partial sums behind.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_sr_q <= '0;
                b_sr_q <= '0;
            end else begin
                for (int i = k - 1; i > 0; i--) begin
                    a_sr_q[i] <= a_sr_q[i-1];
                    b_sr_q[i] <= b_sr_q[i-1];
                end
                a_sr_q[0] <= a_gated[k];
                b_sr_q[0] <= b_gated[k];
            end
        end

        assign bus.arr_a_out[k] = a_sr_q[k-1];
        assign bus.arr_b_out[k] = b_sr_q[k-1];
    end

    // Result lane j leaves the array j cycles after lane 0; delay it by SIZE-1-j.
    assign aligned[SIZE-1] = bus.arr_res_in[SIZE-1];

    for (genvar j = 0; j < SIZE - 1; j++) begin : g_deskew
        localparam int D = SIZE - 1 - j;
        word_t [D-1:0] sr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_q <= '0;
            end else begin
                for (int i = D - 1; i > 0; i--) sr_q[i] <= sr_q[i-1];
                sr_q[0] <= bus.arr_res_in[j];
            end
        end

        assign aligned[j] = sr_q[D-1];
    end

    assign bus.rd_en_out     = rd_en;
    assign bus.rd_addr_out   = rd_en ? addr_q : '0;
    assign bus.arr_en_out    = ((state_q == S_FEED) && rd_vld_q) || (state_q == S_DRAIN);
    assign bus.arr_sum_out   = bias_q;
    assign bus.res_valid_out = res_vld;
    assign bus.res_out       = res_vld ? aligned : '0;
    assign bus.busy_out      = (state_q != S_IDLE);
    assign bus.done_out      = (state_q == S_DONE);
endmodule

// File: tb/tb_hs_npu_systolic_ctrl.sv
// Directed bench for hs_npu_systolic_ctrl at SIZE=4 with an operand buffer model and a
// per-lane stand-in array whose lane latency matches the sequencer's skew budget.
module tb_hs_npu_systolic_ctrl;
    localparam int SIZE    = 4;
    localparam int ROW_W   = 16;
    localparam int ARR_LAT = 2 * SIZE - 1;
    localparam int HIST    = 64;

    typedef logic [SIZE-1:0][15:0] srow_t;
    typedef logic [SIZE-1:0][31:0] wrow_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    hs_npu_systolic_ctrl_if #(.SIZE(SIZE), .ROW_W(ROW_W)) bus ();

    hs_npu_systolic_ctrl #(.SIZE(SIZE), .ROW_W(ROW_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    srow_t mem_a [16];
    srow_t mem_b [16];
    wrow_t apipe [ARR_LAT];

    // Operand buffer: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (bus.rd_en_out) begin
            bus.rd_a_in <= mem_a[bus.rd_addr_out[3:0]];
            bus.rd_b_in <= mem_b[bus.rd_addr_out[3:0]];
        end else begin
            bus.rd_a_in <= {SIZE{16'hBAD0}};
            bus.rd_b_in <= {SIZE{16'hBAD1}};
        end
    end

    // Stand-in array: each lane returns sum + a*b, ARR_LAT cycles after its operands.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARR_LAT; i++) apipe[i] <= '0;
        end else begin
            for (int j = 0; j < SIZE; j++)
                apipe[0][j] <= bus.arr_sum_out[j] + 32'(bus.arr_a_out[j]) * 32'(bus.arr_b_out[j]);
            for (int i = 1; i < ARR_LAT; i++) apipe[i] <= apipe[i-1];
        end
    end
    assign bus.arr_res_in = apipe[ARR_LAT-1];

    logic [15:0] rd_addrs [$];
    int          rd_cycs  [$];
    wrow_t       res_rows [$];
    int          res_cycs [$];
    int          cyc, done_cyc, done_cnt, en_first, en_cnt;
    logic        busy1;
    srow_t       hist_b  [HIST];
    logic        hist_en [HIST];

    function automatic wrow_t exp_row(input logic [15:0] addr, input wrow_t bias);
        wrow_t r;
        srow_t a, b;
        a = mem_a[addr[3:0]];
        b = mem_b[addr[3:0]];
        for (int j = 0; j < SIZE; j++) r[j] = bias[j] + 32'(a[j]) * 32'(b[j]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic sample();
        if (bus.rd_en_out) begin
            rd_addrs.push_back(bus.rd_addr_out);
            rd_cycs.push_back(cyc);
        end
        if (bus.res_valid_out) begin
            res_rows.push_back(bus.res_out);
            res_cycs.push_back(cyc);
        end
        if (bus.arr_en_out) begin
            if (en_first < 0) en_first = cyc;
            en_cnt++;
        end
        if (bus.done_out) begin
            if (done_cyc < 0) done_cyc = cyc;
            done_cnt++;
        end
        if (cyc == 1) busy1 = bus.busy_out;
        if (cyc < HIST) begin
            hist_b[cyc]  = bus.arr_b_out;
            hist_en[cyc] = bus.arr_en_out;
        end
    endtask

    // Cycle 1 is the first cycle after the edge that samples start_in.
    task automatic run_job(input logic [15:0] rows, input logic [15:0] base,
                           input wrow_t bias, input int glitch_cyc, input int budget);
        int post;
        rd_addrs.delete(); rd_cycs.delete(); res_rows.delete(); res_cycs.delete();
        done_cyc = -1; done_cnt = 0; en_first = -1; en_cnt = 0; busy1 = 1'b0;
        for (int i = 0; i < HIST; i++) begin
            hist_b[i]  = '0;
            hist_en[i] = 1'b0;
        end
        bus.start_in = 1'b1;
        bus.rows_in  = rows;
        bus.base_in  = base;
        bus.bias_in  = bias;
        cyc = 0;
        tick();
        bus.start_in = 1'b0;
        sample();
        post = 0;
        while (cyc < budget && post < 4) begin
            if (cyc == glitch_cyc) begin
                bus.start_in = 1'b1;
                bus.rows_in  = 16'd9;
                bus.base_in  = 16'h0040;
                bus.bias_in  = {SIZE{32'h5555}};
            end
            tick();
            bus.start_in = 1'b0;
            sample();
            if (done_cyc >= 0) post++;
        end
    endtask

    task automatic test_reset();
        int act;
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                repeat (2) @(posedge clk);
                #1;
            end else begin
                bus.start_in = 1'b1;
                bus.rows_in  = 16'd10;
                bus.base_in  = 16'h0010;
                bus.bias_in  = {SIZE{32'd7}};
                tick();
                bus.start_in = 1'b0;
                tick();
                tick();
                total++;
                if ({bus.busy_out, bus.rd_en_out} !== 2'b11) begin
                    bad++;
                    $display("FAIL reset_midfeed_setup busy/rd_en got %b want 11",
                             {bus.busy_out, bus.rd_en_out});
                end
                rst_n = 1'b0;
                #1;
            end
            total++;
            if ({bus.rd_en_out, bus.arr_en_out, bus.res_valid_out, bus.busy_out, bus.done_out} !== 5'b0) begin
                bad++;
                $display("FAIL reset%0d_flags got %b want 00000", phase,
                         {bus.rd_en_out, bus.arr_en_out, bus.res_valid_out, bus.busy_out, bus.done_out});
            end
            total++;
            if (bus.rd_addr_out !== 16'h0) begin
                bad++;
                $display("FAIL reset%0d_rd_addr got %h want 0000", phase, bus.rd_addr_out);
            end
            total++;
            if ({bus.arr_a_out, bus.arr_b_out} !== '0) begin
                bad++;
                $display("FAIL reset%0d_arr_ab got %h/%h want 0", phase, bus.arr_a_out, bus.arr_b_out);
            end
            total++;
            if (bus.arr_sum_out !== '0) begin
                bad++;
                $display("FAIL reset%0d_arr_sum got %h want 0", phase, bus.arr_sum_out);
            end
            total++;
            if (bus.res_out !== '0) begin
                bad++;
                $display("FAIL reset%0d_res got %h want 0", phase, bus.res_out);
            end
            tick();
            tick();
            rst_n = 1'b1;
            if (phase == 1) begin
                act = 0;
                for (int i = 0; i < 30; i++) begin
                    tick();
                    if (bus.rd_en_out || bus.res_valid_out || bus.done_out || bus.arr_en_out) act++;
                end
                total++;
                if (act !== 0) begin
                    bad++;
                    $display("FAIL reset_aborted_activity got %0d active cycles want 0", act);
                end
            end
        end
    endtask

    task automatic test_single_row();
        mem_a[5] = {16'd0, 16'd0, 16'd0, 16'd1};
        mem_b[5] = {SIZE{16'd2}};
        run_job(16'd1, 16'd5, '0, -1, 60);
        total++;
        if (rd_addrs.size() != 1 || rd_addrs[0] !== 16'd5 || rd_cycs[0] != 1) begin
            bad++;
            $display("FAIL single_rd got n=%0d want one read of addr 0005 at cycle 1", rd_addrs.size());
        end
        total++;
        if (res_cycs.size() != 1 || res_cycs[0] != 12) begin
            bad++;
            $display("FAIL single_res_time got n=%0d want one result at cycle 12", res_cycs.size());
        end else begin
            total++;
            if (res_rows[0] !== {32'd0, 32'd0, 32'd0, 32'd2}) begin
                bad++;
                $display("FAIL single_res_data got %h want lane0=2 others 0", res_rows[0]);
            end
        end
        for (int k = 0; k < SIZE; k++) begin
            total++;
            if (hist_b[1+k][k] !== 16'd0 || hist_b[2+k][k] !== 16'd2) begin
                bad++;
                $display("FAIL single_skew_lane%0d got %h,%h want 0000,0002", k,
                         hist_b[1+k][k], hist_b[2+k][k]);
            end
        end
        total++;
        if (en_first != 2 || en_cnt != 11) begin
            bad++;
            $display("FAIL single_arr_en got first=%0d cnt=%0d want first=2 cnt=11", en_first, en_cnt);
        end
        total++;
        if (done_cyc != 13 || done_cnt != 1 || busy1 !== 1'b1) begin
            bad++;
            $display("FAIL single_done got cyc=%0d cnt=%0d busy=%b want 13,1,1", done_cyc, done_cnt, busy1);
        end
    endtask

    task automatic test_back_to_back();
        wrow_t bias;
        bias = {32'd1, 32'd2, 32'd3, 32'd4};
        run_job(16'd6, 16'h0020, bias, -1, 80);
        total++;
        if (rd_addrs.size() != 6) begin
            bad++;
            $display("FAIL b2b_rd_count got %0d want 6", rd_addrs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (rd_addrs[i] !== 16'(16'h0020 + i) || rd_cycs[i] != 1 + i) begin
                    bad++;
                    $display("FAIL b2b_rd%0d got %h@%0d want %h@%0d", i, rd_addrs[i], rd_cycs[i],
                             16'(16'h0020 + i), 1 + i);
                end
            end
        end
        total++;
        if (res_rows.size() != 6) begin
            bad++;
            $display("FAIL b2b_res_count got %0d want 6", res_rows.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (res_rows[i] !== exp_row(16'(16'h0020 + i), bias) || res_cycs[i] != 12 + i) begin
                    bad++;
                    $display("FAIL b2b_res%0d got %h@%0d want %h@%0d", i, res_rows[i], res_cycs[i],
                             exp_row(16'(16'h0020 + i), bias), 12 + i);
                end
            end
        end
        total++;
        if (done_cyc != 18) begin
            bad++;
            $display("FAIL b2b_done got %0d want 18", done_cyc);
        end
        total++;
        if (done_cyc >= 0 && done_cyc < HIST && hist_en[done_cyc] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_arr_en_in_done got 1 want 0");
        end
    endtask

    task automatic test_zero_rows();
        run_job(16'd0, 16'h0030, {SIZE{32'd9}}, -1, 20);
        total++;
        if (rd_addrs.size() != 0 || en_cnt != 0 || res_rows.size() != 0) begin
            bad++;
            $display("FAIL zero_activity got rd=%0d en=%0d res=%0d want 0,0,0",
                     rd_addrs.size(), en_cnt, res_rows.size());
        end
        // done is visible in the cycle after the start sampling edge (start cycle + 1)
        total++;
        if (done_cyc != 1 || done_cnt != 1 || busy1 !== 1'b1) begin
            bad++;
            $display("FAIL zero_done got cyc=%0d cnt=%0d busy=%b want 1,1,1", done_cyc, done_cnt, busy1);
        end
    endtask

    task automatic test_start_ignored();
        wrow_t bias;
        bias = {32'd40, 32'd30, 32'd20, 32'd10};
        run_job(16'd3, 16'h0008, bias, 2, 60);
        total++;
        if (rd_addrs.size() != 3 || res_rows.size() != 3 || done_cnt != 1) begin
            bad++;
            $display("FAIL ignore_counts got rd=%0d res=%0d done=%0d want 3,3,1",
                     rd_addrs.size(), res_rows.size(), done_cnt);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (rd_addrs[i] !== 16'(16'h0008 + i) || res_rows[i] !== exp_row(16'(16'h0008 + i), bias)) begin
                    bad++;
                    $display("FAIL ignore_row%0d got %h/%h want %h/%h", i, rd_addrs[i], res_rows[i],
                             16'(16'h0008 + i), exp_row(16'(16'h0008 + i), bias));
                end
            end
        end
        total++;
        if (done_cyc != 15) begin
            bad++;
            $display("FAIL ignore_done got %0d want 15", done_cyc);
        end
    endtask

    task automatic test_addr_wrap();
        wrow_t       bias;
        logic [15:0] want [4];
        bias = {SIZE{32'd100}};
        want[0] = 16'hFFFE;
        want[1] = 16'hFFFF;
        want[2] = 16'h0000;
        want[3] = 16'h0001;
        run_job(16'd4, 16'hFFFE, bias, -1, 60);
        total++;
        if (rd_addrs.size() != 4 || res_rows.size() != 4) begin
            bad++;
            $display("FAIL wrap_counts got rd=%0d res=%0d want 4,4", rd_addrs.size(), res_rows.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (rd_addrs[i] !== want[i] || res_rows[i] !== exp_row(want[i], bias)) begin
                    bad++;
                    $display("FAIL wrap_row%0d got %h/%h want %h/%h", i, rd_addrs[i], res_rows[i],
                             want[i], exp_row(want[i], bias));
                end
            end
        end
    endtask

    initial begin
        bus.start_in = 1'b0;
        bus.rows_in  = '0;
        bus.base_in  = '0;
        bus.bias_in  = '0;
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < SIZE; k++) begin
                mem_a[i][k] = 16'(i * 16 + k + 1);
                mem_b[i][k] = 16'(3 + i + 2 * k);
            end
        test_reset();
        test_single_row();
        test_back_to_back();
        test_zero_rows();
        test_start_ignored();
        test_addr_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
